data_mem_ctrl: RTL and testbench

Parametrised byte-addressable data memory controller for the pipeline's MEM stage. It replaces the single-cycle, asynchronous-read data memory with a synchronous word-organised RAM behind a valid/ready request port. The port decodes RISC-V load/store `funct3` (LB/LH/LW/LBU/LHU, SB/SH/SW) and drives byte-lane enables. Misaligned accesses are either split into two word accesses or reported as errors; out-of-range and illegal accesses return an error instead of silently corrupting memory.

---
 rtl/dmem_pkg.sv | 54 +++++
 rtl/dmem_word_ram.sv | 31 +++
 rtl/data_mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller:
// funct3 codes, FSM state, access size, byte-lane masks and load extension.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        SECOND,
        RESP
    } state_t;

    // Bytes touched: 1, 2 or 4, from the low two funct3 bits.
    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic legal_code(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Lanes [3:0] belong to the addressed word, [7:4] to the next word.
    function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        logic [7:0] m;
        case (size)
            3'd1:    m = 8'h01;
            3'd2:    m = 8'h03;
            default: m = 8'h0f;
        endcase
        return m << off;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {{24{d[7]}}, d[7:0]};
            F3_H:    return {{16{d[15]}}, d[15:0]};
            F3_BU:   return {24'h0, d[7:0]};
            F3_HU:   return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Single-port word RAM with byte enables and registered read; no reset so a
// block RAM macro can take its place.
module dmem_word_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b])
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Valid/ready data memory controller: decodes RISC-V load/store widths,
// splits word-crossing accesses and reports illegal/out-of-range accesses.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned SPLIT_MISALIGN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned IDX1_W = ADDR_W - 1;
    localparam int unsigned RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t           state;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      hi_data_q;
    logic [3:0]       hi_be_q;
    logic [31:0]      lo_q;
    logic             split_q;

    logic [1:0]       a_off;
    logic [IDX_W-1:0] a_idx;
    logic [2:0]       a_size;
    logic [7:0]       a_mask;
    logic             a_two;
    logic             a_mis;
    logic             a_oor;
    logic             a_err;
    logic [63:0]      a_shift;

    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [31:0]       word_lo;
    logic [31:0]       merged;

    assign req_ready = (state == IDLE);

    // Decode of the incoming request; the error decision is made here.
    always_comb begin
        a_off   = req_addr[1:0];
        a_idx   = req_addr[ADDR_W-1:2];
        a_size  = access_size(req_funct3);
        a_mask  = lane_mask(a_size, a_off);
        a_two   = |a_mask[7:4];
        a_mis   = ((a_size == 3'd2) && a_off[0]) || ((a_size == 3'd4) && (a_off != 2'd0));
        a_oor   = ({1'b0, a_idx} >= IDX1_W'(DEPTH_WORDS)) ||
                  (a_two && (({1'b0, a_idx} + IDX1_W'(1)) >= IDX1_W'(DEPTH_WORDS)));
        a_err   = !legal_code(req_we, req_funct3) || a_oor ||
                  ((SPLIT_MISALIGN == 0) && a_mis);
        a_shift = {32'h0, req_wdata} << {a_off, 3'b000};
    end

    // RAM port: first (or only) word in the accept cycle, next word in SECOND.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'h0;
        ram_addr  = '0;
        ram_wdata = 32'h0;
        if (rst_n && (state == IDLE) && req_valid && !a_err) begin
            ram_en    = 1'b1;
            ram_we    = req_we;
            ram_be    = a_mask[3:0];
            ram_addr  = RAM_AW'(a_idx);
            ram_wdata = a_shift[31:0];
        end else if (rst_n && (state == SECOND)) begin
            ram_en    = 1'b1;
            ram_we    = we_q;
            ram_be    = hi_be_q;
            ram_addr  = RAM_AW'(idx_q + IDX_W'(1));
            ram_wdata = hi_data_q;
        end
    end

    dmem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            idx_q     <= '0;
            hi_data_q <= 32'h0;
            hi_be_q   <= 4'h0;
            lo_q      <= 32'h0;
            split_q   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        off_q     <= a_off;
                        idx_q     <= a_idx;
                        hi_data_q <= a_shift[63:32];
                        hi_be_q   <= a_mask[7:4];
                        split_q   <= a_two && !a_err;
                        if (a_two && !a_err) begin
                            state <= SECOND;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= a_err;
                        end
                    end
                end
                SECOND: begin
                    lo_q      <= ram_rdata;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Load merge: the low word comes from lo_q after a split, else straight from the RAM.
    always_comb begin
        word_lo   = split_q ? lo_q : ram_rdata;
        merged    = 32'({ram_rdata, word_lo} >> {off_q, 3'b000});
        rsp_rdata = (rsp_valid && !rsp_err && !we_q) ? extend(f3_q, merged) : 32'h0;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboarded bench for data_mem_ctrl, plus a second instance built without
// misaligned-access splitting.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata, rsp_rdata;
    logic              rsp_valid, rsp_err;

    logic              s0_valid, s0_ready, s0_we;
    logic [2:0]        s0_funct3;
    logic [ADDR_W-1:0] s0_addr;
    logic [31:0]       s0_wdata, s0_rdata;
    logic              s0_rsp_valid, s0_err;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .SPLIT_MISALIGN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .SPLIT_MISALIGN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s0_valid), .req_ready(s0_ready), .req_we(s0_we),
        .req_funct3(s0_funct3), .req_addr(s0_addr), .req_wdata(s0_wdata),
        .rsp_valid(s0_rsp_valid), .rsp_rdata(s0_rdata), .rsp_err(s0_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tag = 0;
    int last_acc = -100;
    int prev_gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response",
                         rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("rsp%0d_rdata", e.tag), rsp_rdata, e.rdata);
                check($sformatf("rsp%0d_err", e.tag), 32'(rsp_err), 32'(e.err));
                check($sformatf("rsp%0d_cycle", e.tag), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Present a request and leave req_valid high; lat=0 means no response is expected.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat, input bit gap_chk);
        int g;
        int acc;
        g = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: req_ready=0 after %0d cycles, required 1", g);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (gap_chk)
            check("accept_gap", 32'(acc - last_acc), 32'(prev_gap));
        last_acc = acc;
        prev_gap = lat + 1;
        tag++;
        if (lat > 0)
            sb.push_back('{er, ee, acc + lat - 1, tag});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run0(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input string nm);
        @(negedge clk);
        s0_valid  = 1'b1;
        s0_we     = we;
        s0_funct3 = f3;
        s0_addr   = a;
        s0_wdata  = wd;
        check({nm, "_ready"}, 32'(s0_ready), 32'd1);
        @(posedge clk);
        #1 s0_valid = 1'b0;
        @(negedge clk);
        check({nm, "_valid"}, 32'(s0_rsp_valid), 32'd1);
        check({nm, "_err"}, 32'(s0_err), 32'(ee));
        check({nm, "_rdata"}, s0_rdata, er);
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = 32'h0;
        s0_valid = 1'b0; s0_we = 1'b0; s0_funct3 = 3'd0; s0_addr = '0; s0_wdata = 32'h0;

        #12;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // aligned store/load and extension
        issue(1'b1, F3_W,  12'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1'b0);
        issue(1'b0, F3_W,  12'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1, 1'b0);
        issue(1'b0, F3_B,  12'h013, 32'h0,        32'hFFFFFFDE, 1'b0, 1, 1'b0);
        issue(1'b0, F3_BU, 12'h013, 32'h0,        32'h000000DE, 1'b0, 1, 1'b0);
        issue(1'b0, F3_H,  12'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 1, 1'b0);
        idle();

        // split word
        issue(1'b1, F3_W,  12'h011, 32'h11223344, 32'h0,        1'b0, 2, 1'b0);
        issue(1'b0, F3_W,  12'h011, 32'h0,        32'h11223344, 1'b0, 2, 1'b0);
        @(negedge clk);
        check("split_ready_t1", 32'(req_ready), 32'd0);
        issue(1'b0, F3_BU, 12'h011, 32'h0,        32'h00000044, 1'b0, 1, 1'b0);
        issue(1'b0, F3_BU, 12'h014, 32'h0,        32'h00000011, 1'b0, 1, 1'b0);
        issue(1'b0, F3_BU, 12'h010, 32'h0,        32'h000000EF, 1'b0, 1, 1'b0);

        // split halfword
        issue(1'b1, F3_H,  12'h023, 32'h00008001, 32'h0,        1'b0, 2, 1'b0);
        issue(1'b0, F3_H,  12'h023, 32'h0,        32'hFFFF8001, 1'b0, 2, 1'b0);
        issue(1'b0, F3_HU, 12'h023, 32'h0,        32'h00008001, 1'b0, 2, 1'b0);

        // errors and top-of-memory boundary
        issue(1'b0, F3_W,  12'(4*DEPTH-2), 32'h0, 32'h0,        1'b1, 1, 1'b0);
        issue(1'b1, F3_W,  12'(4*DEPTH-4), 32'hCAFEF00D, 32'h0, 1'b0, 1, 1'b0);
        issue(1'b0, F3_W,  12'(4*DEPTH-4), 32'h0, 32'hCAFEF00D, 1'b0, 1, 1'b0);
        issue(1'b1, 3'd4,  12'h010, 32'h00000000, 32'h0,        1'b1, 1, 1'b0);
        issue(1'b0, F3_W,  12'h010, 32'h0,        32'h223344EF, 1'b0, 1, 1'b0);
        issue(1'b0, 3'd3,  12'h010, 32'h0,        32'h0,        1'b1, 1, 1'b0);
        issue(1'b0, 3'd6,  12'h010, 32'h0,        32'h0,        1'b1, 1, 1'b0);

        // reset in the SECOND cycle of a split store
        issue(1'b1, F3_W,  12'h030, 32'h00000000, 32'h0,        1'b0, 1, 1'b0);
        issue(1'b1, F3_W,  12'h034, 32'h55555555, 32'h0,        1'b0, 1, 1'b0);
        issue(1'b1, F3_W,  12'h031, 32'hAABBCCDD, 32'h0,        1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("midsplit_rst_ready", 32'(req_ready), 32'd1);
        check("midsplit_rst_valid", 32'(rsp_valid), 32'd0);
        check("midsplit_rst_err", 32'(rsp_err), 32'd0);
        check("midsplit_rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("post_rst_ready", 32'(req_ready), 32'd1);
        issue(1'b0, F3_BU, 12'h031, 32'h0, 32'h000000DD, 1'b0, 1, 1'b0);
        issue(1'b0, F3_BU, 12'h032, 32'h0, 32'h000000CC, 1'b0, 1, 1'b0);
        issue(1'b0, F3_BU, 12'h033, 32'h0, 32'h000000BB, 1'b0, 1, 1'b0);
        issue(1'b0, F3_BU, 12'h034, 32'h0, 32'h00000055, 1'b0, 1, 1'b0);
        issue(1'b0, F3_BU, 12'h030, 32'h0, 32'h00000000, 1'b0, 1, 1'b0);

        // req_valid held high across alternating stores and loads
        issue(1'b1, F3_W, 12'h040, 32'h01020304, 32'h0,        1'b0, 1, 1'b0);
        issue(1'b0, F3_W, 12'h040, 32'h0,        32'h01020304, 1'b0, 1, 1'b1);
        issue(1'b1, F3_W, 12'h040, 32'hA0B0C0D0, 32'h0,        1'b0, 1, 1'b1);
        issue(1'b0, F3_W, 12'h040, 32'h0,        32'hA0B0C0D0, 1'b0, 1, 1'b1);
        issue(1'b1, F3_W, 12'h043, 32'h0F1E2D3C, 32'h0,        1'b0, 2, 1'b1);
        issue(1'b0, F3_W, 12'h043, 32'h0,        32'h0F1E2D3C, 1'b0, 2, 1'b1);
        issue(1'b0, F3_W, 12'h040, 32'h0,        32'h3CB0C0D0, 1'b0, 1, 1'b1);
        idle();

        // instance without splitting
        run0(1'b1, F3_W, 12'h004, 32'h12345678, 32'h0,        1'b0, "ns_sw");
        run0(1'b0, F3_W, 12'h004, 32'h0,        32'h12345678, 1'b0, "ns_lw");
        run0(1'b0, F3_W, 12'h001, 32'h0,        32'h0,        1'b1, "ns_lw_mis");
        run0(1'b0, F3_H, 12'h006, 32'h0,        32'h00001234, 1'b0, "ns_lh");
        run0(1'b0, F3_H, 12'h005, 32'h0,        32'h0,        1'b1, "ns_lh_mis");

        begin
            int g;
            g = 0;
            while (sb.size() != 0 && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (sb.size() != 0) begin
                tests++;
                fails++;
                $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
